// File: rtl/fwrisc_csr_rmw.sv
// CSR read-modify-write sequencer: one rb read, then rd write (old value) and CSR write (new value).
// Optional build macro FWRISC_CSR_RO_CHECK_EN rejects writes to the read-only CSR block 0x38-0x3F.
module fwrisc_csr_rmw #(
    parameter logic [5:0] CSR_BASE = 6'h20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [5:0]  req_csr,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1_idx,
    input  logic [31:0] req_src,
    output logic [5:0]  rb_raddr,
    input  logic [31:0] rb_rdata,
    output logic [5:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        rd_wen,
    output logic        done,
    output logic        illegal,
    output logic [31:0] result
);

    localparam logic [1:0] OP_ILL = 2'b00;
    localparam logic [1:0] OP_RW  = 2'b01;
    localparam logic [1:0] OP_RS  = 2'b10;
    localparam logic [1:0] OP_RC  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WR_RD  = 3'd2,
        WR_CSR = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t      state_r;
    logic [1:0]  op_r;
    logic [5:0]  csr_r;
    logic [4:0]  rd_r;
    logic [31:0] src_r;
    logic        do_write_r;
    logic [5:0]  rb_raddr_r;
    logic [5:0]  rd_waddr_r;
    logic [31:0] rd_wdata_r;
    logic        rd_wen_r;
    logic        done_r;
    logic        illegal_r;
    logic [31:0] result_r;

    logic        do_write_req_s;
    logic        ro_hit_s;
    logic        illegal_req_s;

    function automatic logic [31:0] csr_new_value(
        input logic [1:0]  op,
        input logic [31:0] old_val,
        input logic [31:0] src
    );
        logic [31:0] nv;
        case (op)
            OP_RW:   nv = src;
            OP_RS:   nv = old_val | src;
            OP_RC:   nv = old_val & ~src;
            default: nv = old_val;
        endcase
        return nv;
    endfunction

    // Legality of the request currently offered on the req_* bus.
    always_comb begin
        do_write_req_s = (req_op == OP_RW) || (req_rs1_idx != 5'd0);
`ifdef FWRISC_CSR_RO_CHECK_EN
        ro_hit_s = do_write_req_s && (req_csr[5:3] == 3'b111);
`else
        ro_hit_s = 1'b0;
`endif
        illegal_req_s = (req_op == OP_ILL) || (req_csr < CSR_BASE) || ro_hit_s;
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            op_r       <= OP_ILL;
            csr_r      <= 6'd0;
            rd_r       <= 5'd0;
            src_r      <= 32'd0;
            do_write_r <= 1'b0;
            rb_raddr_r <= 6'd0;
            rd_waddr_r <= 6'd0;
            rd_wdata_r <= 32'd0;
            rd_wen_r   <= 1'b0;
            done_r     <= 1'b0;
            illegal_r  <= 1'b0;
            result_r   <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    rd_wen_r  <= 1'b0;
                    done_r    <= 1'b0;
                    illegal_r <= 1'b0;
                    if (req_valid) begin
                        op_r       <= req_op;
                        csr_r      <= req_csr;
                        rd_r       <= req_rd;
                        src_r      <= req_src;
                        do_write_r <= do_write_req_s;
                        rb_raddr_r <= req_csr;
                        if (illegal_req_s) begin
                            state_r   <= ERR;
                            done_r    <= 1'b1;
                            illegal_r <= 1'b1;
                            result_r  <= 32'd0;
                        end else begin
                            state_r <= READ;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    // The GPR write is armed now; its data arrives with rb_rdata next cycle.
                    rd_waddr_r <= {1'b0, rd_r};
                    rd_wen_r   <= (rd_r != 5'd0);
                    state_r    <= WR_RD;
                end
                WR_RD: begin
                    rd_waddr_r <= csr_r;
                    rd_wdata_r <= csr_new_value(op_r, rb_rdata, src_r);
                    rd_wen_r   <= do_write_r;
                    done_r     <= 1'b1;
                    illegal_r  <= 1'b0;
                    result_r   <= rb_rdata;
                    state_r    <= WR_CSR;
                end
                WR_CSR: begin
                    rd_wen_r <= 1'b0;
                    done_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                ERR: begin
                    rd_wen_r  <= 1'b0;
                    done_r    <= 1'b0;
                    illegal_r <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    rd_wen_r  <= 1'b0;
                    done_r    <= 1'b0;
                    illegal_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_r == IDLE);
    assign rb_raddr  = rb_raddr_r;
    assign rd_waddr  = rd_waddr_r;
    // The regfile read is registered, so the old value can only be forwarded straight through in WR_RD.
    assign rd_wdata  = (state_r == WR_RD) ? rb_rdata : rd_wdata_r;
    assign rd_wen    = rd_wen_r;
    assign done      = done_r;
    assign illegal   = illegal_r;
    assign result    = result_r;

endmodule

// File: doc/fwrisc_csr_rmw.md
Name: fwrisc_csr_rmw

Overview:
- Sequencer that initiates CSR read-modify-write accesses (CSRRW/CSRRS/CSRRC and immediate forms) against the register file.
- Drives the regfile's rb read port and rd write port.
- Sits between the decode/exec stage and the regfile; the exec stage hands over one request and gets a done pulse plus the old CSR value.
- Each request costs one read plus up to two writes through the single rd port, so the access is serialised by a small state machine.

Parameters:
- CSR_BASE, 6'h20: lowest regfile index of the CSR window. Requests with csr_addr below this are illegal.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block idle, can accept
- req_op  input  2  2'b01 RW, 2'b10 RS, 2'b11 RC, 2'b00 illegal
- req_csr  input  6  regfile index of target CSR
- req_rd  input  5  destination GPR index
- req_rs1_idx  input  5  rs1 index, or uimm for immediate forms; used only for write-suppress
- req_src  input  32  source operand (rs1 value or zero-extended uimm)
- rb_raddr  output  6  regfile rb read address
- rb_rdata  input  32  regfile rb data; registered read, valid the cycle after address
- rd_waddr  output  6  regfile write address
- rd_wdata  output  32  regfile write data
- rd_wen  output  1  regfile write enable
- done  output  1  one-cycle completion pulse
- illegal  output  1  qualifies done: request rejected
- result  output  32  old CSR value, valid while done=1

Behaviour:
- States: IDLE, READ, WR_RD, WR_CSR, ERR. req_ready=1 only in IDLE.
- Reset values: state IDLE; rb_raddr=0; rd_wen=0; rd_waddr=0; rd_wdata=0; done=0; illegal=0; result=0.
- All request fields are latched on accept (req_valid && req_ready).
- IDLE: on accept, go to ERR if req_op==0 or req_csr<CSR_BASE; otherwise go to READ.
- READ (T+1): rb_raddr=csr_q; no write.
- WR_RD (T+2): rb_rdata now valid.
  - old_q<=rb_rdata.
  - rd_waddr={1'b0,rd_q}, rd_wdata=rb_rdata, rd_wen=(rd_q!=0).
- WR_CSR (T+3): rd_waddr=csr_q, rd_wdata=new, rd_wen=do_write; done=1, result=old_q. Next state IDLE.
- new value: RW = src; RS = old|src; RC = old&~src. All 32-bit, no carries.
- do_write = (op==RW) || (rs1_idx_q!=0). RS/RC with rs1/uimm of x0/0 must not write the CSR, so read side effects only.
- ERR (T+1): done=1, illegal=1, result=0, rd_wen=0. Next state IDLE.
- Accept-to-done latency: 3 cycles legal, 1 cycle illegal. A new request can be accepted the cycle after done, so throughput is 1 per 4 cycles.
- rd_wen is deasserted in IDLE, READ and ERR. rb_raddr holds csr_q until the next accept.
- req_valid while busy: ignored (req_ready=0); the requester must hold it.
- Reset mid-operation: return to IDLE next edge; any pending write is dropped and no done is issued.
- Writing rd before the CSR guarantees the GPR sees the pre-modify value. rd and csr can never alias, because rd<32 and csr>=CSR_BASE.

Optional Feature:
- FWRISC_CSR_RO_CHECK_EN, defined: a request with do_write=1 and req_csr[5:3]==3'b111 (read-only CSR block 0x38-0x3F) goes to ERR (done+illegal, no writes).
- RS/RC with do_write=0 to that block is legal and completes normally.
- Undefined: no check is made; such writes proceed and the regfile alone decides whether storage is updated.

Test Plan:
- RW: CSR 0x2A=0x12345678, rd=5, src=0xDEADBEEF → T+2 write x5=0x12345678; T+3 write 0x2A=0xDEADBEEF; done at T+3 with result=0x12345678.
- RS: CSR 0x2A=0x0000F000, src=0x0000000F, rs1_idx=3 → CSR becomes 0x0000F00F. RC with src=0x0000F000 → CSR becomes 0x0000000F.
- RS with rs1_idx=0, rd=7, CSR=0xA5A5A5A5 → x7=0xA5A5A5A5; rd_wen=0 in WR_CSR; done pulses.
- rd=0 with RW → no rd_wen in WR_RD, CSR still written. req_op=0 or req_csr=0x10 → done+illegal at T+1, zero writes.
- Back-to-back req_valid held high → accepts spaced 4 cycles apart; reset asserted in WR_RD → no write in the following cycles, no done, req_ready=1 after reset.
- With FWRISC_CSR_RO_CHECK_EN: RW to 0x3C → illegal, no writes. RS rs1_idx=0 to 0x3C → legal read; without the macro, RW to 0x3C issues the CSR write.
